// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } arb_gnt_e;

  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  // On a conflict the data port wins unless rotation is enabled, in which case
  // the port that did not win last time is chosen.
  function automatic arb_gnt_e pick_grant(input logic if_elig, input logic dm_elig,
                                          input arb_gnt_e last_gnt, input logic rr_en);
    arb_gnt_e gnt;
    if (if_elig && dm_elig) begin
      if (rr_en && (last_gnt == GNT_DM)) begin
        gnt = GNT_IF;
      end else begin
        gnt = GNT_DM;
      end
    end else if (dm_elig) begin
      gnt = GNT_DM;
    end else begin
      gnt = GNT_IF;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Saturating wait counter for an outstanding memory access; expire asserts once
// the count reaches LIMIT.
module mem_arb_timer #(
  parameter int LIMIT = 255,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expire
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;

  // Counter register: clear beats load beats increment; holds at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = (cnt_r >= LIMIT_C);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between the fetch and data requesters.
// Define MEM_ARB_RR_EN to rotate grants on conflicts instead of favouring data.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_data_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic              err_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_DATA);

  arb_state_e        state_r, state_s;
  arb_gnt_e          gnt_sel_s;
  logic              if_elig_s, dm_elig_s;
  logic              grant_s, done_s, tmo_s, busy_s, expire_s, timer_clr_s;
  logic              mem_req_r, mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              if_ack_r, dm_ack_r, err_r;
  logic [DATA_W-1:0] if_data_r, dm_rdata_r;

  // A requester whose ack is showing is still holding last access's request.
  assign if_elig_s   = if_req_i & ~if_ack_r;
  assign dm_elig_s   = dm_req_i & ~dm_ack_r;
  assign busy_s      = (state_r == BUSY_IF) || (state_r == BUSY_DM);
  assign timer_clr_s = done_s | tmo_s;

`ifdef MEM_ARB_RR_EN
  arb_gnt_e last_gnt_r;

  assign gnt_sel_s = pick_grant(if_elig_s, dm_elig_s, last_gnt_r, 1'b1);

  // Remembers the winner of the most recent grant for rotation.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_gnt_r <= GNT_IF;
    end else if (grant_s) begin
      last_gnt_r <= gnt_sel_s;
    end else begin
      last_gnt_r <= last_gnt_r;
    end
  end
`else
  assign gnt_sel_s = pick_grant(if_elig_s, dm_elig_s, GNT_IF, 1'b0);
`endif

  // Next-state and grant/completion decode.
  always_comb begin
    state_s = state_r;
    grant_s = 1'b0;
    done_s  = 1'b0;
    tmo_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (if_elig_s || dm_elig_s) begin
          grant_s = 1'b1;
          if (gnt_sel_s == GNT_DM) begin
            state_s = BUSY_DM;
          end else begin
            state_s = BUSY_IF;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ack_i) begin
          done_s  = 1'b1;
          state_s = IDLE;
        end else if (expire_s) begin
          tmo_s   = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and memory-side request registers, latched at grant time.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
    end else begin
      state_r   <= state_s;
      mem_req_r <= (state_s != IDLE);
      if (grant_s) begin
        if (gnt_sel_s == GNT_DM) begin
          mem_addr_r  <= dm_addr_i;
          mem_we_r    <= dm_we_i;
          mem_wdata_r <= dm_wdata_i;
        end else begin
          mem_addr_r  <= if_addr_i;
          mem_we_r    <= 1'b0;
          mem_wdata_r <= {DATA_W{1'b0}};
        end
      end
    end
  end

  // Requester-side completion: ack pulses, returned data, sticky timeout flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      if_ack_r   <= 1'b0;
      dm_ack_r   <= 1'b0;
      if_data_r  <= {DATA_W{1'b0}};
      dm_rdata_r <= {DATA_W{1'b0}};
      err_r      <= 1'b0;
    end else begin
      if_ack_r <= (done_s | tmo_s) & (state_r == BUSY_IF);
      dm_ack_r <= (done_s | tmo_s) & (state_r == BUSY_DM);
      if (state_r == BUSY_IF) begin
        if (done_s) begin
          if_data_r <= mem_rdata_i;
        end else if (tmo_s) begin
          if_data_r <= ERR_WORD;
        end
      end
      if (state_r == BUSY_DM) begin
        if (done_s && !mem_we_r) begin
          dm_rdata_r <= mem_rdata_i;
        end else if (tmo_s) begin
          dm_rdata_r <= ERR_WORD;
        end
      end
      if (tmo_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // First busy cycle counts as one, so expiry lands on busy cycle TIMEOUT_CYC.
  mem_arb_timer #(
    .LIMIT (TIMEOUT_CYC),
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr      (timer_clr_s),
    .load     (grant_s),
    .load_val (CNT_W'(1)),
    .en       (busy_s),
    .expire   (expire_s)
  );

  assign mem_req_o   = mem_req_r;
  assign mem_we_o    = mem_we_r;
  assign mem_addr_o  = mem_addr_r;
  assign mem_wdata_o = mem_wdata_r;
  assign if_ack_o    = if_ack_r;
  assign if_data_o   = if_data_r;
  assign dm_ack_o    = dm_ack_r;
  assign dm_rdata_o  = dm_rdata_r;
  assign err_o       = err_r;
  assign stall_o     = (if_req_i & ~if_ack_r) | (dm_req_i & ~dm_ack_r);

endmodule
